// File: rtl/v8_param_pkg.sv
// ---------------------------------------------------------------------------
// v8_param
//   Shared constants and types for the v8 shaping-filter chain.
//   Adds the synthetic pulse-generator settings, its FSM state type and
//   the saturating accumulator adder used by v8_pulse_gen.
// ---------------------------------------------------------------------------
package v8_param;

    // ADC sample width (signed samples on the filter input interface)
    localparam int SIZE_ADC_DATA   = 12;

    // Pulse generator defaults
    localparam int GEN_FRAC        = 8;   // accumulator fractional bits
    localparam int GEN_RISE_SHIFT  = 2;   // rise length = 2^GEN_RISE_SHIFT cycles
    localparam int GEN_DECAY_SHIFT = 4;   // tau ~ 2^GEN_DECAY_SHIFT samples
    localparam int GEN_PERIOD      = 64;  // auto-trigger interval in cycles

    typedef enum logic [1:0] {
        GEN_IDLE,
        GEN_RISE,
        GEN_DECAY
    } v8_gen_state_t;

    // Unsigned add that sticks at lim instead of wrapping. Operands are
    // carried at 64 bits so the carry out of the caller's width is visible.
    function automatic logic [63:0] gen_sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input logic [63:0] lim
    );
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, lim}) begin
            return lim;
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/v8_period_timer.sv
// ---------------------------------------------------------------------------
// v8_period_timer
//   Free-running interval counter for the pulse generator's auto-trigger.
//   Counts while en is high, restarts after PERIOD-1, and is held at zero
//   while en is low.
//
//   clk    in  clock
//   reset  in  asynchronous, active-low reset
//   en     in  count enable (auto_en of the generator)
//   tick   out high while the count sits at PERIOD-1 and en is high
// ---------------------------------------------------------------------------
module v8_period_timer
    import v8_param::*;
#(
    parameter int PERIOD = GEN_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] period_cnt;
    logic          at_last;

    assign at_last = (period_cnt == LAST);
    assign tick    = en & at_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_cnt <= '0;
        end else if (!en || at_last) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/v8_pulse_gen.sv
// ---------------------------------------------------------------------------
// v8_pulse_gen
//   Synthetic ADC-sample source for the v8 shaping-filter input. Produces
//   detector-like pulses: a linear rise of 2^RISE_SHIFT cycles followed by a
//   first-order exponential decay, riding on a signed baseline. Triggers
//   arriving during the decay tail pile up on the remaining charge.
//
//   clk          in  clock
//   reset        in  asynchronous, active-low reset
//   trig         in  pulse request, sampled on rising clk
//   auto_en      in  enable periodic internal trigger
//   amp          in  unsigned amplitude, latched on an accepted trigger
//   baseline     in  signed offset added every cycle
//   adc_data     out signed generated sample (registered)
//   busy         out high while rising or decaying
//   pulse_start  out one-cycle strobe on an accepted trigger
//   trig_lost    out one-cycle strobe for a trigger that arrived mid-rise
// ---------------------------------------------------------------------------
module v8_pulse_gen #(
    parameter int SIZE_ADC_DATA = v8_param::SIZE_ADC_DATA,
    parameter int GEN_FRAC      = v8_param::GEN_FRAC,
    parameter int RISE_SHIFT    = v8_param::GEN_RISE_SHIFT,
    parameter int DECAY_SHIFT   = v8_param::GEN_DECAY_SHIFT,
    parameter int PERIOD        = v8_param::GEN_PERIOD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trig,
    input  logic                     auto_en,
    input  logic [SIZE_ADC_DATA-1:0] amp,
    input  logic [SIZE_ADC_DATA-1:0] baseline,
    output logic [SIZE_ADC_DATA-1:0] adc_data,
    output logic                     busy,
    output logic                     pulse_start,
    output logic                     trig_lost
);

    import v8_param::*;

    // Two extra integer bits give headroom for piled-up pulses
    localparam int ACC_W = SIZE_ADC_DATA + GEN_FRAC + 2;
    localparam int SUM_W = SIZE_ADC_DATA + GEN_FRAC + 3;
    localparam int RCW   = RISE_SHIFT + 1;

    localparam logic [ACC_W-1:0]        ACC_MAX   = '1;
    localparam logic [RCW-1:0]          RISE_LAST = RCW'((1 << RISE_SHIFT) - 1);
    localparam logic signed [SUM_W-1:0] OUT_MAX   = SUM_W'((1 << (SIZE_ADC_DATA - 1)) - 1);
    localparam logic signed [SUM_W-1:0] OUT_MIN   = SUM_W'(-(1 << (SIZE_ADC_DATA - 1)));

    v8_gen_state_t              state;
    logic [ACC_W-1:0]           acc;
    logic [RCW-1:0]             rise_cnt;
    logic [SIZE_ADC_DATA-1:0]   amp_lat;

    logic                       auto_tick;
    logic                       t_eff;
    logic [ACC_W-1:0]           rise_inc;
    logic [ACC_W-1:0]           acc_rise;
    logic [ACC_W-1:0]           acc_decay;
    logic                       acc_int_zero;
    logic signed [SUM_W-1:0]    sum;
    logic [SIZE_ADC_DATA-1:0]   adc_next;

    v8_period_timer #(
        .PERIOD (PERIOD)
    ) u_period_timer (
        .clk   (clk),
        .reset (reset),
        .en    (auto_en),
        .tick  (auto_tick)
    );

    assign t_eff = trig | auto_tick;

    // Each of the 2^RISE_SHIFT adds contributes amp / 2^RISE_SHIFT in
    // accumulator units, so the full rise lands exactly on amp << GEN_FRAC.
    always_comb begin
        rise_inc     = ACC_W'(amp_lat) << (GEN_FRAC - RISE_SHIFT);
        acc_rise     = ACC_W'(gen_sat_add(64'(acc), 64'(rise_inc), 64'(ACC_MAX)));
        acc_decay    = acc - (acc >> DECAY_SHIFT);
        acc_int_zero = ((acc >> GEN_FRAC) == '0);
    end

    // Output stage: integer part of acc on top of the sign-extended baseline,
    // clamped to the signed sample range.
    always_comb begin
        sum = SUM_W'($signed(baseline)) + $signed(SUM_W'(acc >> GEN_FRAC));
        if (sum > OUT_MAX) begin
            adc_next = OUT_MAX[SIZE_ADC_DATA-1:0];
        end else if (sum < OUT_MIN) begin
            adc_next = OUT_MIN[SIZE_ADC_DATA-1:0];
        end else begin
            adc_next = sum[SIZE_ADC_DATA-1:0];
        end
    end

    // busy is assigned in every branch from the state being entered, so it
    // rises on the same edge the FSM leaves IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= GEN_IDLE;
            acc         <= '0;
            rise_cnt    <= '0;
            amp_lat     <= '0;
            adc_data    <= '0;
            busy        <= 1'b0;
            pulse_start <= 1'b0;
            trig_lost   <= 1'b0;
        end else begin
            adc_data    <= adc_next;
            pulse_start <= 1'b0;
            trig_lost   <= 1'b0;

            case (state)
                GEN_IDLE: begin
                    if (t_eff) begin
                        amp_lat     <= amp;
                        rise_cnt    <= '0;
                        pulse_start <= 1'b1;
                        busy        <= 1'b1;
                        state       <= GEN_RISE;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                GEN_RISE: begin
                    acc       <= acc_rise;
                    rise_cnt  <= rise_cnt + 1'b1;
                    trig_lost <= t_eff;
                    busy      <= 1'b1;
                    if (rise_cnt == RISE_LAST) begin
                        state <= GEN_DECAY;
                    end
                end

                GEN_DECAY: begin
                    // A pile-up trigger wins over the exit test so a pulse
                    // arriving on the last tail sample is never dropped; the
                    // new rise starts from the undecayed acc.
                    if (t_eff) begin
                        amp_lat     <= amp;
                        rise_cnt    <= '0;
                        pulse_start <= 1'b1;
                        busy        <= 1'b1;
                        state       <= GEN_RISE;
                    end else if (acc_int_zero) begin
                        acc   <= '0;
                        busy  <= 1'b0;
                        state <= GEN_IDLE;
                    end else begin
                        acc  <= acc_decay;
                        busy <= 1'b1;
                    end
                end

                default: begin
                    acc   <= '0;
                    busy  <= 1'b0;
                    state <= GEN_IDLE;
                end
            endcase
        end
    end

endmodule
